// File: rtl/rdat_wdat_pkg.sv
// Shared definitions for the per-ASC 3WI read-data (RDAT) and write-data (WDAT) paths.
package rdat_wdat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rdat_state_t;

    localparam int FRAME_W_ASC0 = 77;
    localparam int FRAME_W_ASCN = 51;

    // Counter must be able to hold FRAME_W itself, hence the +1.
    function automatic int bit_cnt_w(input int frame_w);
        return $clog2(frame_w + 1);
    endfunction

endpackage

// File: rtl/rdat_err_counter.sv
// Saturating event counter with synchronous clear; clear wins over an increment.
module rdat_err_counter #(
    parameter int W = 8
) (
    input  logic         clk_3wi,
    input  logic         rst_n_3wi,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk_3wi or negedge rst_n_3wi) begin
        if (!rst_n_3wi) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rdat_deframer.sv
// Deframes serial 3WI RDAT frames from one ASC into parallel words with a
// valid/ready holding register, parity/stop checking and an error counter.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   ST_IDLE   | line idle, waiting for start bit (rx_q == 0)
//   ST_DATA   | shifting FRAME_W payload bits, MSB first
//   ST_PARITY | capturing the even-parity bit
//   ST_STOP   | checking stop bit, delivering or flagging
//   ST_BREAK  | line held low after framing error, wait for high
module rdat_deframer
    import rdat_wdat_pkg::*;
#(
    parameter int FRAME_W   = FRAME_W_ASCN,
    parameter int PARITY_EN = 1,
    parameter int ERRCNT_W  = 8
) (
    input  logic                clk_3wi,
    input  logic                rst_n_3wi,
    input  logic                asc_rdat,
    output logic [FRAME_W-1:0]  rdat_word,
    output logic                rdat_valid,
    input  logic                rdat_ready,
    output logic                err_parity,
    output logic                err_frame,
    output logic                rdat_ovr,
    output logic [ERRCNT_W-1:0] err_cnt,
    input  logic                err_cnt_clr,
    output logic                busy
);

    localparam int CNT_W = bit_cnt_w(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    rdat_state_t        state_q;
    logic               rx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRAME_W-1:0] shift_q;
    logic               par_q;
    logic               par_ok;
    logic               err_inc;

    assign par_ok  = (PARITY_EN == 0) || ((^shift_q) == par_q);
    assign busy    = (state_q != ST_IDLE);
    assign err_inc = err_parity | err_frame | rdat_ovr;

    always_ff @(posedge clk_3wi or negedge rst_n_3wi) begin
        if (!rst_n_3wi) begin
            state_q    <= ST_IDLE;
            rx_q       <= 1'b1;
            cnt_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            rdat_word  <= '0;
            rdat_valid <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            rdat_ovr   <= 1'b0;
        end else begin
            rx_q       <= asc_rdat;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            rdat_ovr   <= 1'b0;
            if (rdat_valid && rdat_ready) begin
                rdat_valid <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!rx_q) begin
                        state_q <= ST_DATA;
                        cnt_q   <= '0;
                    end
                end
                ST_DATA: begin
                    shift_q <= {shift_q[FRAME_W-2:0], rx_q};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    par_q   <= rx_q;
                    state_q <= ST_STOP;
                end
                ST_STOP: begin
                    // A bad stop bit masks any parity result for the frame.
                    if (!rx_q) begin
                        err_frame <= 1'b1;
                        state_q   <= ST_BREAK;
                    end else begin
                        state_q <= ST_IDLE;
                        if (!par_ok) begin
                            err_parity <= 1'b1;
                        end else if (!rdat_valid || rdat_ready) begin
                            rdat_word  <= shift_q;
                            rdat_valid <= 1'b1;
                        end else begin
                            rdat_ovr <= 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    rdat_err_counter #(
        .W(ERRCNT_W)
    ) u_err_counter (
        .clk_3wi  (clk_3wi),
        .rst_n_3wi(rst_n_3wi),
        .inc      (err_inc),
        .clr      (err_cnt_clr),
        .cnt      (err_cnt)
    );

endmodule

// File: tb/tb_rdat_deframer.sv
// Bench for rdat_deframer (FRAME_W=51): table-driven frames, a cycle-accurate
// holding-register/error-counter model fed from a scoreboard queue, plus corner sequences.
module tb_rdat_deframer;

    localparam int FW = 51;

    logic          clk_3wi = 1'b0;
    logic          rst_n_3wi = 1'b1;
    logic          asc_rdat = 1'b1;
    logic [FW-1:0] rdat_word;
    logic          rdat_valid;
    logic          rdat_ready = 1'b1;
    logic          err_parity;
    logic          err_frame;
    logic          rdat_ovr;
    logic [7:0]    err_cnt;
    logic          err_cnt_clr = 1'b0;
    logic          busy;

    rdat_deframer #(.FRAME_W(FW), .PARITY_EN(1), .ERRCNT_W(8)) dut (
        .clk_3wi    (clk_3wi),
        .rst_n_3wi  (rst_n_3wi),
        .asc_rdat   (asc_rdat),
        .rdat_word  (rdat_word),
        .rdat_valid (rdat_valid),
        .rdat_ready (rdat_ready),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .rdat_ovr   (rdat_ovr),
        .err_cnt    (err_cnt),
        .err_cnt_clr(err_cnt_clr),
        .busy       (busy)
    );

    always #5 clk_3wi = ~clk_3wi;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk_3wi) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            due;
        bit            good;
        logic [FW-1:0] payload;
        bit            perr;
        bit            ferr;
    } rec_t;
    rec_t sb_q[$];

    logic          e_valid = 1'b0, e_perr = 1'b0, e_ferr = 1'b0, e_ovr = 1'b0;
    logic [FW-1:0] e_word = '0;
    logic [7:0]    e_cnt = '0;
    logic          n_valid, n_perr, n_ferr, n_ovr;
    logic [FW-1:0] n_word;
    rec_t          r;

    // Reference model: expectations for the current cycle, then next-cycle state.
    always @(negedge clk_3wi) begin
        if (!rst_n_3wi) begin
            e_valid = 0; e_word = '0; e_perr = 0; e_ferr = 0; e_ovr = 0; e_cnt = '0;
            sb_q.delete();
            chk("rst_valid", {63'd0, rdat_valid}, 64'd0);
            chk("rst_word", {13'd0, rdat_word}, 64'd0);
            chk("rst_cnt", {56'd0, err_cnt}, 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
        end else begin
            chk("valid", {63'd0, rdat_valid}, {63'd0, e_valid});
            chk("word", {13'd0, rdat_word}, {13'd0, e_word});
            chk("err_parity", {63'd0, err_parity}, {63'd0, e_perr});
            chk("err_frame", {63'd0, err_frame}, {63'd0, e_ferr});
            chk("rdat_ovr", {63'd0, rdat_ovr}, {63'd0, e_ovr});
            chk("err_cnt", {56'd0, err_cnt}, {56'd0, e_cnt});
            n_valid = e_valid; n_word = e_word; n_perr = 0; n_ferr = 0; n_ovr = 0;
            if (e_valid && rdat_ready) n_valid = 0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc + 1) begin
                r = sb_q.pop_front();
                if (r.good) begin
                    if (!e_valid || rdat_ready) begin
                        n_valid = 1; n_word = r.payload;
                    end else begin
                        n_ovr = 1;
                    end
                end
                n_perr = r.perr;
                n_ferr = r.ferr;
            end
            if (err_cnt_clr) e_cnt = '0;
            else if ((e_perr || e_ferr || e_ovr) && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
            e_valid = n_valid; e_word = n_word; e_perr = n_perr; e_ferr = n_ferr; e_ovr = n_ovr;
        end
    end

    task automatic tick();
        @(posedge clk_3wi);
        #1;
    endtask

    task automatic send_frame(input logic [FW-1:0] p, input bit flip, input bit stop,
                              input bit exp_perr, input bit exp_ferr, input int gap);
        rec_t rec;
        tick(); asc_rdat = 1'b0;
        for (int i = FW - 1; i >= 0; i--) begin
            tick(); asc_rdat = p[i];
        end
        tick(); asc_rdat = (^p) ^ flip;
        tick(); asc_rdat = stop;
        rec.due = cyc + 2;
        rec.good = !exp_perr && !exp_ferr;
        rec.payload = p;
        rec.perr = exp_perr;
        rec.ferr = exp_ferr;
        sb_q.push_back(rec);
        for (int i = 0; i < gap; i++) begin
            tick(); asc_rdat = 1'b1;
        end
    endtask

    typedef struct {
        logic [FW-1:0] payload;
        bit            flip;
        bit            stop;
        bit            ready;
        bit            exp_perr;
        bit            exp_ferr;
    } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{51'h1_2345_6789_ABCD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{51'h1_2345_6789_ABCD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{51'h7_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{51'h0,                1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{51'h5_5555_5555_5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{51'h2_AAAA_AAAA_AAAA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        #1 rst_n_3wi = 1'b0;
        #1 chk("rst_async_busy", {63'd0, busy}, 64'd0);
        repeat (3) tick();
        rst_n_3wi = 1'b1;
        repeat (2) tick();

        foreach (vecs[i]) begin
            rdat_ready = vecs[i].ready;
            send_frame(vecs[i].payload, vecs[i].flip, vecs[i].stop,
                       vecs[i].exp_perr, vecs[i].exp_ferr, 3);
            rdat_ready = 1'b1;
            repeat (2) tick();
        end

        // Stop bit 0 then line held low: stays in BREAK, no false start.
        send_frame(51'h3_0F0F_0F0F_0F0F, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        asc_rdat = 1'b0;
        repeat (10) tick();
        chk("break_busy", {63'd0, busy}, 64'd1);
        asc_rdat = 1'b1;
        repeat (4) tick();
        chk("break_idle", {63'd0, busy}, 64'd0);

        // Overrun: hold first word, drop back-to-back second.
        rdat_ready = 1'b0;
        send_frame(51'h2_AAAA_AAAA_AAAA, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        send_frame(51'h5_5555_5555_5555, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        rdat_ready = 1'b1;
        repeat (3) tick();

        // Consume and reload in the same cycle.
        rdat_ready = 1'b0;
        send_frame(51'h1_1111_2222_3333, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        send_frame(51'h6_4444_5555_6666, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        tick(); asc_rdat = 1'b1; rdat_ready = 1'b1;
        tick(); rdat_ready = 1'b0;
        repeat (3) tick();
        rdat_ready = 1'b1;
        repeat (3) tick();

        // Reset at payload bit 20, then a clean frame.
        tick(); asc_rdat = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(); asc_rdat = i[0];
        end
        rst_n_3wi = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, rdat_valid}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_cnt", {56'd0, err_cnt}, 64'd0);
        repeat (3) tick();
        asc_rdat = 1'b1;
        rst_n_3wi = 1'b1;
        repeat (2) tick();
        send_frame(51'h4_DEAD_BEEF_1234, 1'b0, 1'b1, 1'b0, 1'b0, 4);

        // Saturation and clear.
        for (int k = 0; k < 300; k++) begin
            send_frame(51'h0_0000_0000_0001 << (k % FW), 1'b1, 1'b1, 1'b1, 1'b0, 0);
        end
        tick(); asc_rdat = 1'b1;
        repeat (4) tick();
        chk("sat_cnt", {56'd0, err_cnt}, 64'hFF);
        err_cnt_clr = 1'b1;
        tick(); err_cnt_clr = 1'b0;
        @(negedge clk_3wi);
        chk("clr_cnt", {56'd0, err_cnt}, 64'd0);

        repeat (5) tick();
        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
